// File: rtl/lfsr_seq_pkg.sv
// Shared types, register offsets and LFSR step function for the bus-mapped LFSR sequencer.
package lfsr_seq_pkg;

    typedef enum logic [1:0] {
        STEP_ON_READ = 2'b00,
        FREE_RUN     = 2'b01,
        HALT         = 2'b10,
        RUN_TO_MATCH = 2'b11
    } mode_t;

    localparam logic [2:0] REG_STEP  = 3'd0;
    localparam logic [2:0] REG_STATE = 3'd1;
    localparam logic [2:0] REG_SEED  = 3'd2;
    localparam logic [2:0] REG_CTRL  = 3'd3;
    localparam logic [2:0] REG_MATCH = 3'd4;

    // Widest supported state; callers zero-extend and keep only their low bits.
    localparam int unsigned MAX_W = 16;

    function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] state,
                                                   input logic [MAX_W-1:0] taps);
        return {state[MAX_W-2:0], ^(state & taps)};
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register with load/step/hold control and a parity tap output.
module lfsr_core
    import lfsr_seq_pkg::*;
#(
    parameter int unsigned        STATE_W     = 6,
    parameter logic [STATE_W-1:0] TAPS        = STATE_W'(6'b110000),
    parameter logic [STATE_W-1:0] OUT_TAPS    = STATE_W'(6'b101001),
    parameter logic [STATE_W-1:0] RESET_STATE = STATE_W'(1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [STATE_W-1:0] load_value,
    input  logic               step,
    output logic [STATE_W-1:0] state,
    output logic [STATE_W-1:0] next_state,
    output logic               parity
);

    logic [STATE_W-1:0] state_q;
    logic [MAX_W-1:0]   next_wide;

    assign next_wide  = lfsr_next(MAX_W'(state_q), MAX_W'(TAPS));
    assign next_state = next_wide[STATE_W-1:0];
    assign state      = state_q;
    assign parity     = ^(state_q & OUT_TAPS);

    generate
        if (STATE_W < MAX_W) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^next_wide[MAX_W-1:STATE_W];
        end
    endgenerate

    // Load beats step so a seed write always lands exactly as written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
        end else if (load) begin
            state_q <= load_value;
        end else if (step) begin
            state_q <= next_state;
        end
    end

endmodule

// File: rtl/bus_lfsr_sequencer.sv
// Bus-decoded LFSR sequencer: window/offset decode, mode FSM and run-to-match control.
module bus_lfsr_sequencer
    import lfsr_seq_pkg::*;
#(
    parameter int unsigned        STATE_W     = 6,
    parameter int unsigned        ADDR_W      = 14,
    parameter logic [1:0]         WIN_SEL     = 2'b01,
    parameter logic [STATE_W-1:0] TAPS        = STATE_W'(6'b110000),
    parameter logic [STATE_W-1:0] OUT_TAPS    = STATE_W'(6'b101001),
    parameter logic [STATE_W-1:0] RESET_STATE = STATE_W'(1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sel_n,
    input  logic [ADDR_W-1:0]  addr,
    input  logic               rd_wr,
    input  logic               strobe,
    input  logic [STATE_W-1:0] wdata,
    output logic [STATE_W-1:0] rdata,
    output logic               rdata_oe,
    output logic               dout,
    output logic               dout_oe,
    output logic               match_flag,
    output logic [1:0]         mode
);

    logic               hit;
    logic [2:0]         reg_sel;
    logic               step_rd;
    logic               state_rd;
    logic               seed_wr;
    logic               ctrl_wr;
    logic               match_wr;
    logic               unused_addr;

    mode_t              mode_q, mode_d;
    logic               flag_q, flag_d;
    logic [STATE_W-1:0] match_q, match_d;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic [STATE_W-1:0] load_value;
    logic               parity;
    logic               core_step;
    logic               reached;

    assign hit         = strobe & ~sel_n & (addr[ADDR_W-1 -: 2] == WIN_SEL);
    assign reg_sel     = addr[2:0];
    assign unused_addr = ^addr;

    assign step_rd  = hit & rd_wr & (reg_sel == REG_STEP);
    assign state_rd = hit & rd_wr & (reg_sel == REG_STATE);
    assign seed_wr  = hit & ~rd_wr & (reg_sel == REG_SEED);
    assign ctrl_wr  = hit & ~rd_wr & (reg_sel == REG_CTRL);
    assign match_wr = hit & ~rd_wr & (reg_sel == REG_MATCH);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    assign load_value = (wdata == '0) ? STATE_W'(1) : wdata;

    lfsr_core #(
        .STATE_W     (STATE_W),
        .TAPS        (TAPS),
        .OUT_TAPS    (OUT_TAPS),
        .RESET_STATE (RESET_STATE)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (seed_wr),
        .load_value (load_value),
        .step       (core_step),
        .state      (state),
        .next_state (next_state),
        .parity     (parity)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= STEP_ON_READ;
            flag_q  <= 1'b0;
            match_q <= '0;
        end else begin
            mode_q  <= mode_d;
            flag_q  <= flag_d;
            match_q <= match_d;
        end
    end

    // A control write overrides a completion in the same cycle; the step itself used the old mode.
    always_comb begin
        mode_d  = mode_q;
        flag_d  = flag_q;
        match_d = match_q;
        if (reached) begin
            mode_d = HALT;
            flag_d = 1'b1;
        end
        if (ctrl_wr) begin
            mode_d = mode_t'(wdata[1:0]);
            flag_d = 1'b0;
        end
        if (match_wr) begin
            match_d = wdata;
        end
    end

    always_comb begin
        core_step = 1'b0;
        reached   = 1'b0;
        unique case (mode_q)
            STEP_ON_READ: core_step = step_rd;
            FREE_RUN:     core_step = 1'b1;
            HALT:         core_step = 1'b0;
            RUN_TO_MATCH: begin
                if (state == match_q) begin
                    reached = 1'b1;
                end else begin
                    core_step = 1'b1;
                    reached   = (next_state == match_q);
                end
            end
            default: ;
        endcase
        // A seed write replaces the step, so no completion can be claimed that cycle.
        if (seed_wr) begin
            core_step = 1'b0;
            reached   = 1'b0;
        end
        dout_oe  = step_rd;
        rdata_oe = state_rd;
        rdata    = state_rd ? state : '0;
        dout     = parity;
    end

    assign match_flag = flag_q;
    assign mode       = mode_q;

endmodule
